// File: rtl/vending_pkg.sv
// Shared definitions for the vending-machine controller: coin codes, coin values
// and the change dispenser state encoding.
package vending_pkg;

   typedef enum logic [1:0] {
      COIN_1  = 2'b00,
      COIN_5  = 2'b01,
      COIN_10 = 2'b10,
      COIN_50 = 2'b11
   } coin_t;

   localparam int unsigned VAL_1  = 1;
   localparam int unsigned VAL_5  = 5;
   localparam int unsigned VAL_10 = 10;
   localparam int unsigned VAL_50 = 50;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_ISSUE  = 2'd2,
      ST_FINISH = 2'd3
   } disp_state_t;

   function automatic int unsigned coin_value(coin_t c);
      case (c)
         COIN_1:  return VAL_1;
         COIN_5:  return VAL_5;
         COIN_10: return VAL_10;
         default: return VAL_50;
      endcase
   endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request, coin-ejector and status signals of the change dispenser.
interface change_dispenser_if #(
   parameter int W = 32
);
   logic         req_valid;
   logic [W-1:0] req_amount;
   logic         req_ready;
   logic         coin_valid;
   logic [1:0]   coin_sel;
   logic         coin_ack;
   logic         done;
   logic         short;
   logic [W-1:0] remaining;
   logic         refill;
   logic [3:0]   stock_empty;

   modport master (
      output req_valid, req_amount, coin_ack, refill,
      input  req_ready, coin_valid, coin_sel, done, short, remaining, stock_empty
   );

   modport slave (
      input  req_valid, req_amount, coin_ack, refill,
      output req_ready, coin_valid, coin_sel, done, short, remaining, stock_empty
   );
endinterface

// File: rtl/coin_stock.sv
// Stock counter for one coin denomination: loads INIT_STOCK on reset/refill,
// counts down once per ejected coin and flags empty. Saturates at zero.
module coin_stock #(
   parameter int STOCK_W    = 8,
   parameter int INIT_STOCK = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic dec,
   output logic empty
);
   localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(INIT_STOCK);
   localparam logic [STOCK_W-1:0] ONE      = STOCK_W'(1);

   logic [STOCK_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= INIT_VAL;
      end else if (load) begin
         count <= INIT_VAL;
      end else if (dec && count != '0) begin
         count <= count - ONE;
      end
   end

   assign empty = (count == '0);
endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount out one coin per handshake, largest denomination first,
// limited by per-denomination stock; reports any unpaid shortfall.
module change_dispenser
   import vending_pkg::*;
#(
   parameter int W          = 32,
   parameter int STOCK_W    = 8,
   parameter int INIT_STOCK = 20
) (
   input logic                clk,
   input logic                reset,
   change_dispenser_if.slave  bus
);
   disp_state_t  state;
   logic [W-1:0] remaining_q;
   coin_t        sel_q;
   logic         req_ready_q;
   logic         coin_valid_q;
   logic         done_q;
   logic         short_q;

   logic [3:0]   empty;
   logic [3:0]   dec;
   logic         refill_en;
   coin_t        pick;
   logic         found;

   function automatic logic [W-1:0] coin_amount(coin_t c);
      return W'(coin_value(c));
   endfunction

   assign refill_en = bus.refill && (state == ST_IDLE);

   always_comb begin
      dec = '0;
      if (state == ST_ISSUE && bus.coin_ack) begin
         dec[sel_q] = 1'b1;
      end
   end

   coin_stock #(.STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)) u_stock1 (
      .clk(clk), .reset(reset), .load(refill_en), .dec(dec[COIN_1]), .empty(empty[COIN_1])
   );
   coin_stock #(.STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)) u_stock5 (
      .clk(clk), .reset(reset), .load(refill_en), .dec(dec[COIN_5]), .empty(empty[COIN_5])
   );
   coin_stock #(.STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)) u_stock10 (
      .clk(clk), .reset(reset), .load(refill_en), .dec(dec[COIN_10]), .empty(empty[COIN_10])
   );
   coin_stock #(.STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)) u_stock50 (
      .clk(clk), .reset(reset), .load(refill_en), .dec(dec[COIN_50]), .empty(empty[COIN_50])
   );

   // Largest coin that both fits in the remaining amount and is still in stock.
   always_comb begin
      found = 1'b1;
      pick  = COIN_1;
      if (remaining_q >= coin_amount(COIN_50) && !empty[COIN_50]) begin
         pick = COIN_50;
      end else if (remaining_q >= coin_amount(COIN_10) && !empty[COIN_10]) begin
         pick = COIN_10;
      end else if (remaining_q >= coin_amount(COIN_5) && !empty[COIN_5]) begin
         pick = COIN_5;
      end else if (remaining_q >= coin_amount(COIN_1) && !empty[COIN_1]) begin
         pick = COIN_1;
      end else begin
         found = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         remaining_q  <= '0;
         sel_q        <= COIN_1;
         req_ready_q  <= 1'b1;
         coin_valid_q <= 1'b0;
         done_q       <= 1'b0;
         short_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  remaining_q <= bus.req_amount;
                  short_q     <= 1'b0;
                  req_ready_q <= 1'b0;
                  state       <= (bus.req_amount == '0) ? ST_FINISH : ST_SELECT;
               end
            end
            ST_SELECT: begin
               if (found) begin
                  sel_q        <= pick;
                  coin_valid_q <= 1'b1;
                  state        <= ST_ISSUE;
               end else begin
                  short_q <= 1'b1;
                  state   <= ST_FINISH;
               end
            end
            ST_ISSUE: begin
               if (bus.coin_ack) begin
                  remaining_q  <= remaining_q - coin_amount(sel_q);
                  coin_valid_q <= 1'b0;
                  state        <= (remaining_q == coin_amount(sel_q)) ? ST_FINISH : ST_SELECT;
               end
            end
            default: begin
               // done lands in the first IDLE cycle after FINISH
               done_q      <= 1'b1;
               req_ready_q <= 1'b1;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.coin_valid  = coin_valid_q;
   assign bus.coin_sel    = sel_q;
   assign bus.done        = done_q;
   assign bus.short       = short_q;
   assign bus.remaining   = remaining_q;
   assign bus.stock_empty = empty;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with stocks of 20, 3 and 1 per denomination.
module tb_change_dispenser;
   import vending_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   passed = 0;

   change_dispenser_if #(.W(32)) bus20 ();
   change_dispenser_if #(.W(32)) bus3 ();
   change_dispenser_if #(.W(32)) bus1 ();

   change_dispenser #(.W(32), .STOCK_W(8), .INIT_STOCK(20)) d20 (.clk(clk), .reset(reset), .bus(bus20));
   change_dispenser #(.W(32), .STOCK_W(8), .INIT_STOCK(3))  d3  (.clk(clk), .reset(reset), .bus(bus3));
   change_dispenser #(.W(32), .STOCK_W(8), .INIT_STOCK(1))  d1  (.clk(clk), .reset(reset), .bus(bus1));

   always #5 clk = ~clk;

   logic [1:0] q20[$];
   logic [1:0] q3[$];
   logic [1:0] q1[$];

   always @(posedge clk) begin
      if (bus20.coin_valid && bus20.coin_ack) q20.push_back(bus20.coin_sel);
      if (bus3.coin_valid && bus3.coin_ack)   q3.push_back(bus3.coin_sel);
      if (bus1.coin_valid && bus1.coin_ack)   q1.push_back(bus1.coin_sel);
   end

   function automatic bit same_seq(input logic [1:0] a[$], input logic [1:0] b[$]);
      if (a.size() != b.size()) return 1'b0;
      for (int i = 0; i < a.size(); i++) if (a[i] !== b[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic done_of(input int k);
      case (k)
         20:      return bus20.done;
         3:       return bus3.done;
         default: return bus1.done;
      endcase
   endfunction

   // Leaves the caller #1 after the accept edge.
   task automatic send(input int k, input logic [31:0] amt);
      @(negedge clk);
      case (k)
         20:      begin bus20.req_valid = 1'b1; bus20.req_amount = amt; end
         3:       begin bus3.req_valid  = 1'b1; bus3.req_amount  = amt; end
         default: begin bus1.req_valid  = 1'b1; bus1.req_amount  = amt; end
      endcase
      @(posedge clk); #1;
      bus20.req_valid = 1'b0;
      bus3.req_valid  = 1'b0;
      bus1.req_valid  = 1'b0;
   endtask

   // Edges counted from the accept edge until done is seen; gives up after 200.
   task automatic wait_done(input int k, output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!done_of(k) && cyc < 200);
   endtask

   task automatic test_reset();
      bus20.req_valid = 0; bus20.req_amount = 0; bus20.coin_ack = 0; bus20.refill = 0;
      bus3.req_valid  = 0; bus3.req_amount  = 0; bus3.coin_ack  = 0; bus3.refill  = 0;
      bus1.req_valid  = 0; bus1.req_amount  = 0; bus1.coin_ack  = 0; bus1.refill  = 0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      #1;
      checks++; if (bus20.req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", bus20.req_ready); else passed++;
      checks++; if (bus20.coin_valid !== 1'b0) $display("FAIL rst_coin_valid got %b want 0", bus20.coin_valid); else passed++;
      checks++; if (bus20.coin_sel !== 2'b00) $display("FAIL rst_coin_sel got %b want 00", bus20.coin_sel); else passed++;
      checks++; if (bus20.done !== 1'b0) $display("FAIL rst_done got %b want 0", bus20.done); else passed++;
      checks++; if (bus20.short !== 1'b0) $display("FAIL rst_short got %b want 0", bus20.short); else passed++;
      checks++; if (bus20.remaining !== 32'd0) $display("FAIL rst_remaining got %0d want 0", bus20.remaining); else passed++;
      checks++; if (bus20.stock_empty !== 4'b0000) $display("FAIL rst_empty20 got %b want 0000", bus20.stock_empty); else passed++;
      checks++; if (bus1.stock_empty !== 4'b0000) $display("FAIL rst_empty1 got %b want 0000", bus1.stock_empty); else passed++;
      checks++; if (d20.u_stock50.count !== 8'd20) $display("FAIL rst_stock50 got %0d want 20", d20.u_stock50.count); else passed++;
   endtask

   task automatic test_basic65();
      int cyc;
      logic [1:0] exp[$];
      exp = '{2'd3, 2'd2, 2'd1};
      bus20.coin_ack = 1'b1;
      q20.delete();
      send(20, 65);
      checks++; if (bus20.req_ready !== 1'b0) $display("FAIL b65_busy got %b want 0", bus20.req_ready); else passed++;
      wait_done(20, cyc);
      checks++; if (cyc != 7) $display("FAIL b65_latency got %0d want 7", cyc); else passed++;
      checks++; if (!same_seq(q20, exp)) $display("FAIL b65_coins got %p want %p", q20, exp); else passed++;
      checks++; if (bus20.short !== 1'b0) $display("FAIL b65_short got %b want 0", bus20.short); else passed++;
      checks++; if (bus20.remaining !== 32'd0) $display("FAIL b65_remaining got %0d want 0", bus20.remaining); else passed++;
      checks++; if (bus20.req_ready !== 1'b1) $display("FAIL b65_ready got %b want 1", bus20.req_ready); else passed++;
      checks++; if (d20.u_stock50.count !== 8'd19) $display("FAIL b65_s50 got %0d want 19", d20.u_stock50.count); else passed++;
      checks++; if (d20.u_stock10.count !== 8'd19) $display("FAIL b65_s10 got %0d want 19", d20.u_stock10.count); else passed++;
      checks++; if (d20.u_stock5.count !== 8'd19) $display("FAIL b65_s5 got %0d want 19", d20.u_stock5.count); else passed++;
      checks++; if (d20.u_stock1.count !== 8'd20) $display("FAIL b65_s1 got %0d want 20", d20.u_stock1.count); else passed++;
   endtask

   task automatic test_zero();
      int cyc;
      q20.delete();
      send(20, 0);
      wait_done(20, cyc);
      checks++; if (cyc != 1) $display("FAIL zero_latency got %0d want 1", cyc); else passed++;
      checks++; if (q20.size() != 0) $display("FAIL zero_coins got %0d want 0", q20.size()); else passed++;
      checks++; if (bus20.short !== 1'b0) $display("FAIL zero_short got %b want 0", bus20.short); else passed++;
      @(posedge clk); #1;
      checks++; if (bus20.done !== 1'b0) $display("FAIL zero_done_pulse got %b want 0", bus20.done); else passed++;
   endtask

   task automatic test_stall();
      int cyc;
      bus20.coin_ack = 1'b0;
      q20.delete();
      send(20, 10);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (bus20.coin_valid !== 1'b1) $display("FAIL stall_offer got %b want 1", bus20.coin_valid); else passed++;
      for (int i = 0; i < 5; i++) begin
         bus20.req_valid = 1'b1; bus20.req_amount = 7; bus20.refill = 1'b1;
         @(posedge clk); #1;
         checks++; if (bus20.coin_valid !== 1'b1) $display("FAIL stall_valid%0d got %b want 1", i, bus20.coin_valid); else passed++;
         checks++; if (bus20.coin_sel !== 2'b10) $display("FAIL stall_sel%0d got %b want 10", i, bus20.coin_sel); else passed++;
         checks++; if (bus20.req_ready !== 1'b0) $display("FAIL stall_ready%0d got %b want 0", i, bus20.req_ready); else passed++;
      end
      bus20.req_valid = 1'b0; bus20.refill = 1'b0;
      bus20.coin_ack = 1'b1;
      @(posedge clk); #1;
      bus20.coin_ack = 1'b0;
      checks++; if (bus20.coin_valid !== 1'b0) $display("FAIL stall_withdraw got %b want 0", bus20.coin_valid); else passed++;
      wait_done(20, cyc);
      checks++; if (cyc != 1) $display("FAIL stall_done got %0d want 1", cyc); else passed++;
      checks++; if (q20.size() != 1 || q20[0] !== 2'b10) $display("FAIL stall_coins got %p want '{2}", q20); else passed++;
      checks++; if (bus20.remaining !== 32'd0) $display("FAIL stall_remaining got %0d want 0", bus20.remaining); else passed++;
      checks++; if (d20.u_stock10.count !== 8'd18) $display("FAIL stall_s10 got %0d want 18", d20.u_stock10.count); else passed++;
      checks++; if (d20.u_stock50.count !== 8'd19) $display("FAIL stall_refill_ignored got %0d want 19", d20.u_stock50.count); else passed++;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus20.req_ready !== 1'b1 || bus20.remaining !== 32'd0) $display("FAIL stall_no_queue got ready=%b rem=%0d want 1/0", bus20.req_ready, bus20.remaining); else passed++;
   endtask

   task automatic test_exhaust();
      int cyc;
      logic [1:0] exp[$];
      exp = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
      bus3.coin_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(3, 50);
         wait_done(3, cyc);
      end
      checks++; if (bus3.stock_empty !== 4'b1000) $display("FAIL exh_empty50 got %b want 1000", bus3.stock_empty); else passed++;
      checks++; if (bus3.short !== 1'b0) $display("FAIL exh_short50 got %b want 0", bus3.short); else passed++;
      q3.delete();
      send(3, 60);
      wait_done(3, cyc);
      checks++; if (cyc != 20) $display("FAIL exh_latency got %0d want 20", cyc); else passed++;
      checks++; if (!same_seq(q3, exp)) $display("FAIL exh_coins got %p want %p", q3, exp); else passed++;
      checks++; if (bus3.short !== 1'b1) $display("FAIL exh_short got %b want 1", bus3.short); else passed++;
      checks++; if (bus3.remaining !== 32'd12) $display("FAIL exh_remaining got %0d want 12", bus3.remaining); else passed++;
      checks++; if (bus3.stock_empty !== 4'b1111) $display("FAIL exh_empty got %b want 1111", bus3.stock_empty); else passed++;
   endtask

   task automatic test_refill();
      @(negedge clk) bus3.refill = 1'b1;
      @(posedge clk); #1;
      bus3.refill = 1'b0;
      checks++; if (bus3.stock_empty !== 4'b0000) $display("FAIL refill_empty got %b want 0000", bus3.stock_empty); else passed++;
      checks++; if (d3.u_stock50.count !== 8'd3) $display("FAIL refill_s50 got %0d want 3", d3.u_stock50.count); else passed++;
   endtask

   task automatic test_shortfall();
      int cyc;
      logic [1:0] exp[$];
      exp = '{2'd3, 2'd2, 2'd1, 2'd0};
      bus1.coin_ack = 1'b1;
      q1.delete();
      send(1, 80);
      wait_done(1, cyc);
      checks++; if (cyc != 10) $display("FAIL sf_latency got %0d want 10", cyc); else passed++;
      checks++; if (!same_seq(q1, exp)) $display("FAIL sf_coins got %p want %p", q1, exp); else passed++;
      checks++; if (bus1.short !== 1'b1) $display("FAIL sf_short got %b want 1", bus1.short); else passed++;
      checks++; if (bus1.remaining !== 32'd14) $display("FAIL sf_remaining got %0d want 14", bus1.remaining); else passed++;
      checks++; if (bus1.stock_empty !== 4'b1111) $display("FAIL sf_empty got %b want 1111", bus1.stock_empty); else passed++;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus1.short !== 1'b1 || bus1.remaining !== 32'd14) $display("FAIL sf_hold got short=%b rem=%0d want 1/14", bus1.short, bus1.remaining); else passed++;
      // refill and a new request on the same edge: the request sees full stock
      bus1.refill = 1'b1;
      q1.delete();
      send(1, 80);
      bus1.refill = 1'b0;
      checks++; if (bus1.short !== 1'b0) $display("FAIL sf_short_clear got %b want 0", bus1.short); else passed++;
      wait_done(1, cyc);
      checks++; if (!same_seq(q1, exp)) $display("FAIL sf_refill_coins got %p want %p", q1, exp); else passed++;
      checks++; if (bus1.remaining !== 32'd14) $display("FAIL sf_refill_remaining got %0d want 14", bus1.remaining); else passed++;
   endtask

   task automatic test_reset_mid();
      int cyc;
      bus20.coin_ack = 1'b0;
      send(20, 30);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (bus20.coin_valid !== 1'b1 || bus20.coin_sel !== 2'b10) $display("FAIL rm_offer got v=%b sel=%b want 1/10", bus20.coin_valid, bus20.coin_sel); else passed++;
      #2 reset = 1'b1;
      #1;
      checks++; if (bus20.coin_valid !== 1'b0) $display("FAIL rm_withdraw got %b want 0", bus20.coin_valid); else passed++;
      checks++; if (bus20.req_ready !== 1'b1) $display("FAIL rm_ready got %b want 1", bus20.req_ready); else passed++;
      checks++; if (d20.u_stock10.count !== 8'd20) $display("FAIL rm_s10 got %0d want 20", d20.u_stock10.count); else passed++;
      checks++; if (d20.u_stock50.count !== 8'd20) $display("FAIL rm_s50 got %0d want 20", d20.u_stock50.count); else passed++;
      @(negedge clk) reset = 1'b0;
      bus20.coin_ack = 1'b1;
      q20.delete();
      send(20, 5);
      wait_done(20, cyc);
      checks++; if (cyc != 3) $display("FAIL rm_latency got %0d want 3", cyc); else passed++;
      checks++; if (q20.size() != 1 || q20[0] !== 2'b01) $display("FAIL rm_coins got %p want '{1}", q20); else passed++;
      checks++; if (bus20.short !== 1'b0 || bus20.remaining !== 32'd0) $display("FAIL rm_result got short=%b rem=%0d want 0/0", bus20.short, bus20.remaining); else passed++;
      checks++; if (d20.u_stock5.count !== 8'd19) $display("FAIL rm_s5 got %0d want 19", d20.u_stock5.count); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic65();
      test_zero();
      test_stall();
      test_exhaust();
      test_refill();
      test_shortfall();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
